// File: rtl/hdmi_rd_pkg.sv
// Shared types and default 720p timing for the HDMI FIFO video reader.
package hdmi_rd_pkg;

   typedef enum logic [1:0] {FILL, ARMED, RUN} rd_state_e;

   localparam int unsigned DEF_H_ACTIVE = 1280;
   localparam int unsigned DEF_H_FP     = 110;
   localparam int unsigned DEF_H_SYNC   = 40;
   localparam int unsigned DEF_H_BP     = 220;
   localparam int unsigned DEF_V_ACTIVE = 720;
   localparam int unsigned DEF_V_FP     = 5;
   localparam int unsigned DEF_V_SYNC   = 5;
   localparam int unsigned DEF_V_BP     = 20;

   function automatic int unsigned h_total(input int unsigned act, input int unsigned fp,
                                           input int unsigned sync, input int unsigned bp);
      return act + fp + sync + bp;
   endfunction

   function automatic int unsigned v_total(input int unsigned act, input int unsigned fp,
                                           input int unsigned sync, input int unsigned bp);
      return act + fp + sync + bp;
   endfunction

endpackage

// File: rtl/video_timing_gen.sv
// Free-running raster counters with active/sync terms and a frame-end strobe.
// hcnt is exported only when HDMI_RD_TEST_PATTERN_EN is defined.
module video_timing_gen import hdmi_rd_pkg::*; #(
   parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
   parameter int unsigned H_FP     = DEF_H_FP,
   parameter int unsigned H_SYNC   = DEF_H_SYNC,
   parameter int unsigned H_BP     = DEF_H_BP,
   parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
   parameter int unsigned V_FP     = DEF_V_FP,
   parameter int unsigned V_SYNC   = DEF_V_SYNC,
   parameter int unsigned V_BP     = DEF_V_BP,
   localparam int unsigned HW = $clog2(h_total(H_ACTIVE, H_FP, H_SYNC, H_BP)),
   localparam int unsigned VW = $clog2(v_total(V_ACTIVE, V_FP, V_SYNC, V_BP))
) (
   input  logic          clk,
   input  logic          tb_rst,
`ifdef HDMI_RD_TEST_PATTERN_EN
   output logic [HW-1:0] hcnt_o,
`endif
   output logic          active0,
   output logic          hs_raw,
   output logic          vs_raw,
   output logic          frame_end
);

   localparam int unsigned H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
   localparam int unsigned V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

   // Sync end is kept inclusive so no constant ever needs the value H_TOTAL.
   localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
   localparam logic [HW-1:0] H_SS     = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] H_SE     = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
   localparam logic [VW-1:0] V_SS     = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] V_SE     = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

   logic [HW-1:0] hcnt;
   logic [VW-1:0] vcnt;

   always_ff @(posedge clk or posedge tb_rst) begin
      if (tb_rst) begin
         hcnt <= '0;
         vcnt <= '0;
      end else if (hcnt == H_LAST) begin
         hcnt <= '0;
         vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
      end else begin
         hcnt <= hcnt + 1'b1;
      end
   end

   assign active0   = (hcnt < H_ACT) && (vcnt < V_ACT);
   assign hs_raw    = (hcnt >= H_SS) && (hcnt <= H_SE);
   assign vs_raw    = (vcnt >= V_SS) && (vcnt <= V_SE);
   assign frame_end = (hcnt == H_LAST) && (vcnt == V_LAST);

`ifdef HDMI_RD_TEST_PATTERN_EN
   assign hcnt_o = hcnt;
`endif

endmodule

// File: rtl/hdmi_fifo_video_reader.sv
// Pops the pixel FIFO in raster order and drives registered hs/vs/de/data to the HDMI encoder.
// HDMI_RD_TEST_PATTERN_EN adds test_pat_sel, which replaces FIFO pixels with an hcnt ramp.
module hdmi_fifo_video_reader import hdmi_rd_pkg::*; #(
   parameter int unsigned DATA_WIDTH  = 8,
   parameter int unsigned DEPTH_WIDTH = 13,
   parameter int unsigned START_LEVEL = 4096,
   parameter int unsigned H_ACTIVE    = DEF_H_ACTIVE,
   parameter int unsigned H_FP        = DEF_H_FP,
   parameter int unsigned H_SYNC      = DEF_H_SYNC,
   parameter int unsigned H_BP        = DEF_H_BP,
   parameter int unsigned V_ACTIVE    = DEF_V_ACTIVE,
   parameter int unsigned V_FP        = DEF_V_FP,
   parameter int unsigned V_SYNC      = DEF_V_SYNC,
   parameter int unsigned V_BP        = DEF_V_BP,
   parameter int unsigned SYNC_POL    = 1
) (
   input  logic                  clk,
   input  logic                  tb_rst,
   input  logic [DATA_WIDTH-1:0] fifo_rd_data,
   input  logic                  fifo_rd_empty,
   input  logic [DEPTH_WIDTH:0]  fifo_rd_level,
`ifdef HDMI_RD_TEST_PATTERN_EN
   input  logic                  test_pat_sel,
`endif
   output logic                  fifo_rd_en,
   output logic                  vid_hs,
   output logic                  vid_vs,
   output logic                  vid_de,
   output logic [DATA_WIDTH-1:0] vid_data,
   output logic                  running,
   output logic                  underflow,
   output logic [15:0]           frame_cnt
);

   localparam logic [DEPTH_WIDTH:0] START_LVL = (DEPTH_WIDTH + 1)'(START_LEVEL);
   localparam logic                 SYNC_ON   = 1'(SYNC_POL);

   logic active0, hs_raw, vs_raw, frame_end, tp;
   logic level_ok, uf_now, frame_done;
   logic hs1, vs1, de1, popped1;
   logic bad_q, bad_d;
   rd_state_e state_q, state_d;

`ifdef HDMI_RD_TEST_PATTERN_EN
   localparam int unsigned HW = $clog2(h_total(H_ACTIVE, H_FP, H_SYNC, H_BP));
   logic [HW-1:0]         hcnt;
   logic [DATA_WIDTH-1:0] ramp1;
   assign tp = test_pat_sel;
`else
   assign tp = 1'b0;
`endif

   video_timing_gen #(
      .H_ACTIVE (H_ACTIVE),
      .H_FP     (H_FP),
      .H_SYNC   (H_SYNC),
      .H_BP     (H_BP),
      .V_ACTIVE (V_ACTIVE),
      .V_FP     (V_FP),
      .V_SYNC   (V_SYNC),
      .V_BP     (V_BP)
   ) u_timing (
      .clk       (clk),
      .tb_rst    (tb_rst),
`ifdef HDMI_RD_TEST_PATTERN_EN
      .hcnt_o    (hcnt),
`endif
      .active0   (active0),
      .hs_raw    (hs_raw),
      .vs_raw    (vs_raw),
      .frame_end (frame_end)
   );

   assign level_ok   = fifo_rd_level >= START_LVL;
   assign running    = (state_q == RUN);
   assign fifo_rd_en = active0 && running && !fifo_rd_empty && !tp;
   assign uf_now     = active0 && running && fifo_rd_empty && !tp;
   assign frame_done = running && frame_end && !tp && !bad_q && !uf_now;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         FILL:  if (!tp && level_ok) state_d = ARMED;
         ARMED: begin
            if (tp || !level_ok) state_d = FILL;
            else if (frame_end)  state_d = RUN;
         end
         RUN:   if (tp || (frame_end && (bad_q || uf_now))) state_d = FILL;
         default: state_d = FILL;
      endcase
   end

   // A bad frame is only remembered until its own boundary.
   assign bad_d = (running && !frame_end && !tp) ? (bad_q | uf_now) : 1'b0;

   always_ff @(posedge clk or posedge tb_rst) begin
      if (tb_rst) begin
         state_q   <= FILL;
         bad_q     <= 1'b0;
         underflow <= 1'b0;
         frame_cnt <= '0;
      end else begin
         state_q <= state_d;
         bad_q   <= bad_d;
         if (uf_now)     underflow <= 1'b1;
         if (frame_done) frame_cnt <= frame_cnt + 16'd1;
      end
   end

   // Stage 1 tracks the counter terms; stage 2 meets the FIFO word one cycle after the pop.
   always_ff @(posedge clk or posedge tb_rst) begin
      if (tb_rst) begin
         hs1      <= ~SYNC_ON;
         vs1      <= ~SYNC_ON;
         de1      <= 1'b0;
         popped1  <= 1'b0;
         vid_hs   <= ~SYNC_ON;
         vid_vs   <= ~SYNC_ON;
         vid_de   <= 1'b0;
         vid_data <= '0;
`ifdef HDMI_RD_TEST_PATTERN_EN
         ramp1    <= '0;
`endif
      end else begin
         hs1     <= hs_raw ? SYNC_ON : ~SYNC_ON;
         vs1     <= vs_raw ? SYNC_ON : ~SYNC_ON;
         de1     <= active0;
         popped1 <= fifo_rd_en;
         vid_hs  <= hs1;
         vid_vs  <= vs1;
         vid_de  <= de1;
`ifdef HDMI_RD_TEST_PATTERN_EN
         ramp1    <= (tp && active0) ? DATA_WIDTH'(hcnt) : '0;
         vid_data <= popped1 ? fifo_rd_data : ramp1;
`else
         vid_data <= popped1 ? fifo_rd_data : '0;
`endif
      end
   end

endmodule

// File: tb/tb_hdmi_fifo_video_reader.sv
// Bench for hdmi_fifo_video_reader: FIFO model, frame-level reference model and directed tests.
module tb_hdmi_fifo_video_reader;

   localparam int HA = 8, HFP = 2, HS = 2, HBP = 2;
   localparam int VA = 4, VFP = 1, VS = 1, VBP = 1;
   localparam int HT = HA + HFP + HS + HBP;
   localparam int VT = VA + VFP + VS + VBP;
   localparam int FRAME = HT * VT;
   localparam int SL = 16;

   logic        clk = 1'b0;
   logic        tb_rst = 1'b0;
   logic [7:0]  fifo_rd_data = 8'h00;
   logic        fifo_rd_empty;
   logic [13:0] fifo_rd_level;
   logic        test_pat_sel = 1'b0;
   logic        fifo_rd_en, vid_hs, vid_vs, vid_de, running, underflow;
   logic [7:0]  vid_data;
   logic [15:0] frame_cnt;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   hdmi_fifo_video_reader #(
      .DATA_WIDTH  (8),
      .DEPTH_WIDTH (13),
      .START_LEVEL (SL),
      .H_ACTIVE    (HA),
      .H_FP        (HFP),
      .H_SYNC      (HS),
      .H_BP        (HBP),
      .V_ACTIVE    (VA),
      .V_FP        (VFP),
      .V_SYNC      (VS),
      .V_BP        (VBP),
      .SYNC_POL    (1)
   ) dut (
      .clk           (clk),
      .tb_rst        (tb_rst),
      .fifo_rd_data  (fifo_rd_data),
      .fifo_rd_empty (fifo_rd_empty),
      .fifo_rd_level (fifo_rd_level),
`ifdef HDMI_RD_TEST_PATTERN_EN
      .test_pat_sel  (test_pat_sel),
`endif
      .fifo_rd_en    (fifo_rd_en),
      .vid_hs        (vid_hs),
      .vid_vs        (vid_vs),
      .vid_de        (vid_de),
      .vid_data      (vid_data),
      .running       (running),
      .underflow     (underflow),
      .frame_cnt     (frame_cnt)
   );

   // FIFO model: data appears the cycle after the pop; it is not cleared by tb_rst.
   logic [7:0] mem [0:1023];
   int wr_cnt = 0;
   int rd_cnt = 0;
   assign fifo_rd_level = 14'(wr_cnt - rd_cnt);
   assign fifo_rd_empty = (wr_cnt == rd_cnt);

   always @(posedge clk) begin
      if (fifo_rd_en) begin
         fifo_rd_data <= mem[rd_cnt % 1024];
         rd_cnt <= rd_cnt + 1;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic push(input int n, input int first);
      for (int i = 0; i < n; i++) begin
         mem[wr_cnt % 1024] = 8'(first - i);
         wr_cnt++;
      end
   endtask

   // Reference model: raster position, per-frame run decision, expected output pipeline.
   int  m_h, m_v, m_fc, lvl_prev;
   int  m_pops = 0;
   bit  m_run, m_bad, m_uf, tp_prev;
   bit  s_hs, s_vs, s_de, e_hs, e_vs, e_de;
   logic [7:0] s_data, e_data;

   always @(posedge clk or posedge tb_rst) begin
      if (tb_rst) begin
         m_h = 0; m_v = 0; m_fc = 0; lvl_prev = 0;
         m_run = 0; m_bad = 0; m_uf = 0; tp_prev = 0;
         s_hs = 0; s_vs = 0; s_de = 0; s_data = 8'h00;
         e_hs = 0; e_vs = 0; e_de = 0; e_data = 8'h00;
      end else begin
         bit act, pop, uf;
         int avail;
         act   = (m_h < HA) && (m_v < VA);
         avail = wr_cnt - m_pops;
         pop   = m_run && act && (avail > 0) && !test_pat_sel;
         uf    = m_run && act && (avail == 0) && !test_pat_sel;
         e_hs = s_hs; e_vs = s_vs; e_de = s_de; e_data = s_data;
         s_hs   = (m_h >= HA + HFP) && (m_h < HA + HFP + HS);
         s_vs   = (m_v >= VA + VFP) && (m_v < VA + VFP + VS);
         s_de   = act;
         s_data = pop ? mem[m_pops % 1024] : ((test_pat_sel && act) ? 8'(m_h) : 8'h00);
         if (pop) m_pops++;
         if (uf) begin m_uf = 1; m_bad = 1; end
         if (test_pat_sel) begin
            m_run = 0; m_bad = 0;
         end else if (m_h == HT - 1 && m_v == VT - 1) begin
            if (m_run) begin
               if (!m_bad) m_fc = (m_fc + 1) % 65536;
               m_run = !m_bad;
            end else begin
               m_run = (lvl_prev >= SL) && (avail >= SL) && !tp_prev;
            end
            m_bad = 0;
         end
         lvl_prev = avail;
         tp_prev  = test_pat_sel;
         m_h++;
         if (m_h == HT) begin m_h = 0; m_v = (m_v + 1) % VT; end
      end
   end

   initial begin : compare
      bit act, exp_en;
      int avail;
      forever begin
         @(negedge clk);
         #1;
         act    = (m_h < HA) && (m_v < VA);
         avail  = wr_cnt - m_pops;
         exp_en = m_run && act && (avail > 0) && !test_pat_sel;
         chk("vid_hs",    32'(vid_hs),    32'(e_hs));
         chk("vid_vs",    32'(vid_vs),    32'(e_vs));
         chk("vid_de",    32'(vid_de),    32'(e_de));
         chk("vid_data",  32'(vid_data),  32'(e_data));
         chk("rd_en",     32'(fifo_rd_en), 32'(exp_en));
         chk("running",   32'(running),   32'(m_run));
         chk("underflow", 32'(underflow), 32'(m_uf));
         chk("frame_cnt", 32'(frame_cnt), 32'(m_fc));
         chk("pop_empty", 32'(fifo_rd_en & fifo_rd_empty), 32'd0);
      end
   end

   task automatic wait_running(input string name, input int maxc);
      bit seen = 0;
      for (int i = 0; i < maxc && !seen; i++) begin
         @(negedge clk);
         seen = running;
      end
      chk(name, 32'(seen), 32'd1);
   endtask

   task automatic wait_pos(input int h, input int v);
      for (int i = 0; i < 2 * FRAME; i++) begin
         if (m_h == h && m_v == v) break;
         @(negedge clk);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_hs"},   32'(vid_hs),     32'd0);
      chk({tag, "_vs"},   32'(vid_vs),     32'd0);
      chk({tag, "_de"},   32'(vid_de),     32'd0);
      chk({tag, "_data"}, 32'(vid_data),   32'd0);
      chk({tag, "_en"},   32'(fifo_rd_en), 32'd0);
      chk({tag, "_run"},  32'(running),    32'd0);
      chk({tag, "_uf"},   32'(underflow),  32'd0);
      chk({tag, "_fc"},   32'(frame_cnt),  32'd0);
   endtask

   initial begin : main
      int de_cnt, en_cnt, pops, nde, rd0, col;
      bit run_seen;
      logic [7:0] d0, d1;

      // 1: reset with an empty FIFO, then free-running raster only
      #1 tb_rst = 1'b1;
      #190;
      chk_all_zero("t1_rst");
      @(negedge clk);
      tb_rst = 1'b0;
      de_cnt = 0; en_cnt = 0;
      for (int i = 0; i < FRAME; i++) begin
         @(negedge clk);
         de_cnt += int'(vid_de);
         en_cnt += int'(fifo_rd_en);
      end
      chk("t1_de_per_frame", 32'(de_cnt), 32'd32);
      chk("t1_pops", 32'(en_cnt), 32'd0);
      chk("t1_running", 32'(running), 32'd0);

      // 2: 40 words 0xFF downwards, one full frame in RUN
      push(40, 255);
      wait_running("t2_start", 2 * FRAME);
      chk("t2_frame_cnt0", 32'(frame_cnt), 32'd0);
      pops = 0; nde = 0; d0 = 8'h00; d1 = 8'h00;
      for (int i = 0; i < FRAME; i++) begin
         pops += int'(fifo_rd_en);
         if (vid_de) begin
            if (nde == 0) d0 = vid_data;
            if (nde == 1) d1 = vid_data;
            nde++;
         end
         if (i == 50) push(12, 255 - 40);
         @(negedge clk);
      end
      chk("t2_pops", 32'(pops), 32'd32);
      chk("t2_px0", 32'(d0), 32'hFF);
      chk("t2_px1", 32'(d1), 32'hFE);
      chk("t2_frame_cnt1", 32'(frame_cnt), 32'd1);
      chk("t2_still_run", 32'(running), 32'd1);

      // 3: only 20 words for the second frame
      nde = 0;
      for (int i = 0; i < FRAME; i++) begin
         if (vid_de) begin
            nde++;
            if (nde == 1)  chk("t3_px1", 32'(vid_data), 32'hDF);
            if (nde == 20) chk("t3_px20", 32'(vid_data), 32'hCC);
            if (nde == 21) begin
               chk("t3_uf_px", 32'(vid_data), 32'h00);
               chk("t3_uf_flag", 32'(underflow), 32'd1);
            end
         end
         @(negedge clk);
      end
      chk("t3_running", 32'(running), 32'd0);
      chk("t3_frame_cnt", 32'(frame_cnt), 32'd1);
      chk("t3_empty", 32'(fifo_rd_level), 32'd0);

      // 4: level touches 16 then falls to 15 before the boundary
      wait_pos(0, 1);
      push(16, 16);
      repeat (10) @(negedge clk);
      wr_cnt--;
      rd0 = rd_cnt;
      run_seen = 0;
      for (int i = 0; i < 2 * FRAME; i++) begin
         @(negedge clk);
         run_seen |= running;
      end
      chk("t4_no_run", 32'(run_seen), 32'd0);
      chk("t4_no_pops", 32'(rd_cnt - rd0), 32'd0);

      // 5: reset in the middle of an active line
      push(20, 100);
      wait_running("t5_start", 2 * FRAME);
      wait_pos(3, 1);
      #2 tb_rst = 1'b1;
      #1 chk_all_zero("t5_rst");
      chk("t5_pops_before_rst", 32'(rd_cnt - rd0), 32'd11);
      @(negedge clk);
      @(negedge clk);
      tb_rst = 1'b0;
      #1 chk("t5_fill", 32'(running), 32'd0);
      wait_running("t5_rearm", 2 * FRAME);
      repeat (FRAME) @(negedge clk);

`ifdef HDMI_RD_TEST_PATTERN_EN
      // 6: horizontal ramp instead of FIFO data
      push(40, 200);
      test_pat_sel = 1'b1;
      wait_pos(0, 0);
      col = 0; en_cnt = 0;
      for (int i = 0; i < FRAME; i++) begin
         en_cnt += int'(fifo_rd_en);
         if (vid_de) begin
            chk("t6_ramp", 32'(vid_data), 32'(col));
            col = (col + 1) % HA;
         end
         @(negedge clk);
      end
      chk("t6_pops", 32'(en_cnt), 32'd0);
      chk("t6_running", 32'(running), 32'd0);
      test_pat_sel = 1'b0;
`endif

      repeat (20) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
